// File: rtl/pll_clk_freq_meter.sv
`default_nettype none
// ============================================================================
// Module      : pll_clk_freq_meter
// Description : Counts clk_meas rising edges over a fixed clk_1 gate window
//               and flags the result as in range, out of range or stopped.
// Revision    : 1.0 - initial release
// ============================================================================
module pll_clk_freq_meter #(
    parameter int GATE_CYCLES = 20000,
    parameter int CNT_W       = 16,
    parameter int EXP_MIN     = 14850,
    parameter int EXP_MAX     = 15150
) (
    input  logic             clk_1,
    input  logic             rst,
    input  logic             clk_meas,
    input  logic             en,
    output logic             busy,
    output logic             meas_valid,
    output logic [CNT_W-1:0] meas_count,
    output logic             in_range,
    output logic             stopped
);

    localparam int               c_tmr_w      = (GATE_CYCLES > 2) ? $clog2(GATE_CYCLES) : 1;
    localparam logic [c_tmr_w-1:0] c_timer_load = c_tmr_w'(GATE_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_exp_min    = CNT_W'(EXP_MIN);
    localparam logic [CNT_W-1:0] c_exp_max    = CNT_W'(EXP_MAX);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_SETTLE  = 2'd1,
        S_MEASURE = 2'd2
    } state_t;

    // clk_meas domain: the counter is never reset, only power-up initialised,
    // because rst belongs to clk_1 and clk_meas may not be running.
    logic [CNT_W-1:0] r_meas_bin  = '0;
    logic [CNT_W-1:0] r_meas_gray = '0;
    logic [CNT_W-1:0] w_meas_next;

    assign w_meas_next = r_meas_bin + 1'b1;

    always_ff @(posedge clk_meas) begin
        r_meas_bin  <= w_meas_next;
        r_meas_gray <= w_meas_next ^ (w_meas_next >> 1);
    end

    logic [CNT_W-1:0] r_sync1;
    logic [CNT_W-1:0] r_sync2;
    logic [CNT_W-1:0] r_sync_bin;
    logic [CNT_W-1:0] w_sync_bin;

    always_comb begin
        w_sync_bin = '0;
        for (int i = 0; i < CNT_W; i++) begin
            w_sync_bin[i] = ^(r_sync2 >> i);
        end
    end

    always_ff @(posedge clk_1) begin
        if (!rst) begin
            r_sync1    <= '0;
            r_sync2    <= '0;
            r_sync_bin <= '0;
        end else begin
            r_sync1    <= r_meas_gray;
            r_sync2    <= r_sync1;
            r_sync_bin <= w_sync_bin;
        end
    end

    state_t             r_state;
    logic [1:0]         r_settle;
    logic [c_tmr_w-1:0] r_timer;
    logic [CNT_W-1:0]   r_start_snap;
    logic [CNT_W-1:0]   w_delta;
    logic               r_busy;
    logic               r_meas_valid;
    logic [CNT_W-1:0]   r_meas_count;
    logic               r_in_range;
    logic               r_stopped;

    // Modular subtraction gives the right count even across counter wrap.
    assign w_delta = r_sync_bin - r_start_snap;

    always_ff @(posedge clk_1) begin
        if (!rst) begin
            r_state      <= S_IDLE;
            r_settle     <= 2'd0;
            r_timer      <= '0;
            r_start_snap <= '0;
            r_busy       <= 1'b0;
            r_meas_valid <= 1'b0;
            r_meas_count <= '0;
            r_in_range   <= 1'b0;
            r_stopped    <= 1'b0;
        end else begin
            r_meas_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (en) begin
                        r_state  <= S_SETTLE;
                        r_settle <= 2'd3;
                        r_busy   <= 1'b1;
                    end
                end
                S_SETTLE: begin
                    if (!en) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end else if (r_settle == 2'd0) begin
                        r_start_snap <= r_sync_bin;
                        r_timer      <= c_timer_load;
                        r_state      <= S_MEASURE;
                    end else begin
                        r_settle <= r_settle - 2'd1;
                    end
                end
                S_MEASURE: begin
                    if (!en) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end else if (r_timer == '0) begin
                        // Re-snapshot in the same cycle: windows are back-to-back.
                        r_start_snap <= r_sync_bin;
                        r_timer      <= c_timer_load;
                        r_meas_count <= w_delta;
                        r_in_range   <= (w_delta >= c_exp_min) && (w_delta <= c_exp_max);
                        r_stopped    <= (w_delta == '0);
                        r_meas_valid <= 1'b1;
                    end else begin
                        r_timer <= r_timer - 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign busy       = r_busy;
    assign meas_valid = r_meas_valid;
    assign meas_count = r_meas_count;
    assign in_range   = r_in_range;
    assign stopped    = r_stopped;

endmodule
`default_nettype wire

// File: tb/tb_pll_clk_freq_meter.sv
`default_nettype none
`timescale 1ps/1ps
// Testbench for pll_clk_freq_meter: table rows, random frequencies against an
// ideal edges-per-window model, plus abort and mid-window reset sequences.
module tb_pll_clk_freq_meter;

    localparam int G         = 2000;
    localparam int CW        = 12;
    localparam int EMIN      = 1485;
    localparam int EMAX      = 1515;
    localparam int CLK1_HALF = 25000;

    logic          clk_1;
    logic          rst;
    logic          clk_meas;
    logic          en;
    logic          busy;
    logic          meas_valid;
    logic [CW-1:0] meas_count;
    logic          in_range;
    logic          stopped;

    int total = 0;
    int bad   = 0;
    int half_ps = 33333;

    pll_clk_freq_meter #(
        .GATE_CYCLES (G),
        .CNT_W       (CW),
        .EXP_MIN     (EMIN),
        .EXP_MAX     (EMAX)
    ) dut (
        .clk_1      (clk_1),
        .rst        (rst),
        .clk_meas   (clk_meas),
        .en         (en),
        .busy       (busy),
        .meas_valid (meas_valid),
        .meas_count (meas_count),
        .in_range   (in_range),
        .stopped    (stopped)
    );

    initial clk_1 = 1'b0;
    always #(CLK1_HALF) clk_1 = ~clk_1;

    initial clk_meas = 1'b0;
    always begin
        if (half_ps == 0) begin
            clk_meas = 1'b0;
            #1000;
        end else begin
            #(half_ps) clk_meas = ~clk_meas;
        end
    end

    typedef struct {
        int half;
        int nwin;
        bit exp_ir;
        bit exp_st;
    } vec_t;

    vec_t tbl[5];

    // Ideal number of clk_meas rising edges in one gate window.
    function automatic real exp_count(input int half);
        if (half == 0) return 0.0;
        return real'(G) * 2.0 * CLK1_HALF / (2.0 * half);
    endfunction

    task automatic tick();
        @(posedge clk_1);
        #1;
    endtask

    task automatic chk(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    task automatic chk_count(input string name, input int half);
        real e;
        real d;
        e = exp_count(half);
        d = real'(meas_count) - e;
        if (d < 0.0) d = -d;
        total++;
        if (d > 1.01) begin
            bad++;
            $display("FAIL %s count: got %0d want %0.2f +/-1", name, meas_count, e);
        end
    endtask

    task automatic wait_valid(input int budget, output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!meas_valid && n < budget);
    endtask

    task automatic check_window(input string name, input int half, input bit ir, input bit st);
        chk_count(name, half);
        chk({name, " in_range"}, in_range, ir);
        chk({name, " stopped"}, stopped, st);
    endtask

    task automatic run_freq(input string name, input int half, input int nwin,
                            input bit ir, input bit st);
        int n;
        en = 1'b0;
        half_ps = half;
        repeat (12) tick();
        en = 1'b1;
        wait_valid(G + 100, n);
        chk({name, " first latency"}, n, G + 5);
        check_window(name, half, ir, st);
        for (int w = 1; w < nwin; w++) begin
            wait_valid(G + 100, n);
            chk({name, " period"}, n, G);
            check_window(name, half, ir, st);
        end
    endtask

    initial begin
        int n;
        int vcount;
        logic [CW-1:0] held;

        tbl[0] = '{half: 33333,  nwin: 5, exp_ir: 1'b1, exp_st: 1'b0};
        tbl[1] = '{half: 0,      nwin: 2, exp_ir: 1'b0, exp_st: 1'b1};
        tbl[2] = '{half: 100000, nwin: 2, exp_ir: 1'b0, exp_st: 1'b0};
        tbl[3] = '{half: 34483,  nwin: 2, exp_ir: 1'b0, exp_st: 1'b0};
        tbl[4] = '{half: 50000,  nwin: 2, exp_ir: 1'b0, exp_st: 1'b0};

        rst = 1'b0;
        en  = 1'b0;
        repeat (3) tick();
        chk("reset busy", busy, 0);
        chk("reset meas_valid", meas_valid, 0);
        chk("reset meas_count", meas_count, 0);
        chk("reset in_range", in_range, 0);
        chk("reset stopped", stopped, 0);
        rst = 1'b1;
        tick();

        for (int i = 0; i < 5; i++) begin
            run_freq($sformatf("row%0d", i), tbl[i].half, tbl[i].nwin,
                     tbl[i].exp_ir, tbl[i].exp_st);
        end

        for (int r = 0; r < 4; r++) begin
            int  h;
            real e;
            do begin
                h = $urandom_range(28000, 200000);
                e = exp_count(h);
            end while ((e > EMIN - 3 && e < EMIN + 3) || (e > EMAX - 3 && e < EMAX + 3));
            run_freq($sformatf("rand%0d", r), h, 2, (e >= EMIN && e <= EMAX), 1'b0);
        end

        // Abort mid-window with en=0, then restart.
        run_freq("abort pre", 33333, 1, 1'b1, 1'b0);
        held = meas_count;
        repeat (G / 2) tick();
        en = 1'b0;
        tick();
        chk("abort busy", busy, 0);
        vcount = 0;
        for (int c = 0; c < G + 50; c++) begin
            tick();
            if (meas_valid) vcount++;
        end
        chk("abort no valid", vcount, 0);
        chk("abort held count", meas_count, held);
        en = 1'b1;
        wait_valid(G + 100, n);
        chk("abort restart latency", n, G + 5);
        check_window("abort restart", 33333, 1'b1, 1'b0);

        // One-cycle reset mid-window with en held high.
        repeat (G / 2) tick();
        rst = 1'b0;
        tick();
        chk("midrst busy", busy, 0);
        chk("midrst meas_valid", meas_valid, 0);
        chk("midrst meas_count", meas_count, 0);
        chk("midrst in_range", in_range, 0);
        chk("midrst stopped", stopped, 0);
        rst = 1'b1;
        wait_valid(G + 100, n);
        chk("midrst restart latency", n, G + 5);
        check_window("midrst restart", 33333, 1'b1, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
